// File: rtl/jag_dram_pkg.sv
// Shared types and constants for the jag_dram_responder DRAM model.
package jag_dram_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ROW_OPEN = 2'd1,
    CAS_ACT  = 2'd2,
    REFRESH  = 2'd3
  } bank_state_e;

  localparam int NUM_BANKS   = 2;
  localparam int NUM_LANES   = 8;
  localparam int LANE_W      = 8;
  localparam int WORD_W      = NUM_LANES * LANE_W;
  localparam int MA_W        = 11;
  localparam int CAS_LAT_MIN = 1;
  localparam int CAS_LAT_MAX = 7;

  // Out-of-range latencies are pulled back into the supported window.
  function automatic int clamp_cas_lat(input int lat);
    if (lat < CAS_LAT_MIN) return CAS_LAT_MIN;
    if (lat > CAS_LAT_MAX) return CAS_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/jag_dram_bank.sv
// One DRAM bank: RAS/CAS state machine, row/column latches, storage array and
// the CAS-latency read pipe with hold-while-enabled output.
module jag_dram_bank
  import jag_dram_pkg::*;
#(
  parameter int ROW_BITS = 6,
  parameter int COL_BITS = 6,
  parameter int CAS_LAT  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ras_fall_i,
  input  logic                 ras_rise_i,
  input  logic                 cas_fall_i,
  input  logic                 cas_rise_i,
  input  logic                 cas_low_i,
  input  logic                 oe_n_i,
  input  logic [ROW_BITS-1:0]  row_i,
  input  logic [COL_BITS-1:0]  col_i,
  input  logic [NUM_LANES-1:0] we_n_i,
  input  logic [WORD_W-1:0]    wdata_i,
  output bank_state_e          state_o,
  output logic                 cbr_o,
  output logic                 proto_o,
  output logic                 rd_vld_o,
  output logic [WORD_W-1:0]    rd_data_o
);

  localparam int LAT    = clamp_cas_lat(CAS_LAT);
  localparam int ADDR_W = ROW_BITS + COL_BITS;
  localparam int DEPTH  = 1 << ADDR_W;

  bank_state_e         state_q;
  logic [ROW_BITS-1:0] row_q;
  logic                cbr_q;
  logic                proto_q;
  logic [WORD_W-1:0]   mem_q [DEPTH];

  logic [LAT-1:0]      pipe_vld_q;
  logic [WORD_W-1:0]   pipe_dat_q [LAT];
  logic                hold_vld_q;
  logic [WORD_W-1:0]   hold_dat_q;

  logic [ADDR_W-1:0]   addr;
  logic                cas_hit;
  logic                all_we_off;
  logic                wr_fire;
  logic                rd_fire;
  logic                keep;

  assign addr       = {row_q, col_i};
  assign all_we_off = &we_n_i;
  assign cas_hit    = (state_q == ROW_OPEN) && !ras_rise_i && cas_fall_i;
  assign wr_fire    = cas_hit && !all_we_off;
  assign rd_fire    = cas_hit && all_we_off && !oe_n_i;
  assign keep       = cas_low_i && !oe_n_i;

  always_ff @(posedge clk_i) begin
    cbr_q   <= 1'b0;
    proto_q <= 1'b0;
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ras_fall_i) begin
            if (cas_low_i) begin
              state_q <= REFRESH;
              cbr_q   <= 1'b1;
            end else begin
              state_q <= ROW_OPEN;
              row_q   <= row_i;
            end
          end
        end
        ROW_OPEN: begin
          if (ras_rise_i) begin
            state_q <= IDLE;
          end else if (cas_fall_i) begin
            state_q <= CAS_ACT;
            // A write with the output enable asserted is a bus fight on xd.
            proto_q <= !all_we_off && !oe_n_i;
          end
        end
        CAS_ACT: begin
          if (ras_rise_i) begin
            state_q <= IDLE;
            proto_q <= 1'b1;
          end else if (cas_rise_i) begin
            state_q <= ROW_OPEN;
          end
        end
        REFRESH: begin
          if (ras_rise_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Byte-lane write lands in the same cycle the CAS fall is seen.
  always_ff @(posedge clk_i) begin
    if (wr_fire && !rst_i) begin
      for (int j = 0; j < NUM_LANES; j++) begin
        if (!we_n_i[j]) mem_q[addr][j*LANE_W +: LANE_W] <= wdata_i[j*LANE_W +: LANE_W];
      end
    end
  end

  // Read pipe control: a valid survives only while CAS and OE stay low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_vld_q <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      pipe_vld_q[0] <= rd_fire;
      for (int s = 1; s < LAT; s++) pipe_vld_q[s] <= pipe_vld_q[s-1] && keep;
      hold_vld_q <= rd_vld_o;
    end
  end

  always_ff @(posedge clk_i) begin
    pipe_dat_q[0] <= mem_q[addr];
    for (int s = 1; s < LAT; s++) pipe_dat_q[s] <= pipe_dat_q[s-1];
    hold_dat_q <= rd_data_o;
  end

  assign rd_vld_o  = (pipe_vld_q[LAT-1] || hold_vld_q) && keep;
  assign rd_data_o = pipe_vld_q[LAT-1] ? pipe_dat_q[LAT-1] : hold_dat_q;
  assign state_o   = state_q;
  assign cbr_o     = cbr_q;
  assign proto_o   = proto_q;

endmodule

// File: rtl/jag_dram_responder.sv
// Board-side DRAM model for TOM's memory port: edge detection, two banks,
// refresh counting and protocol-error flagging.
// Optional refresh-interval watchdog: define JAG_DRAM_REFRESH_CHECK_EN.
module jag_dram_responder
  import jag_dram_pkg::*;
#(
  parameter int ROW_BITS = 6,
  parameter int COL_BITS = 6,
  parameter int CAS_LAT  = 2,
  parameter int REF_MAX  = 4096
) (
  input  logic                 xvclk,
  input  logic                 xreset,
  input  logic [MA_W-1:0]      xma,
  input  logic [NUM_BANKS-1:0] xrasl,
  input  logic [NUM_BANKS-1:0] xcasl,
  input  logic                 xoel_0,
  input  logic [NUM_LANES-1:0] xwel,
  input  logic [WORD_W-1:0]    xd_in,
  output logic [WORD_W-1:0]    xd_out,
  output logic                 xd_oe,
  output logic                 proto_err,
  output logic [15:0]          ref_count,
  output logic                 ref_err
);

  logic [NUM_BANKS-1:0] ras_q, cas_q;
  logic [NUM_BANKS-1:0] ras_fall, ras_rise, cas_fall, cas_rise;
  logic [NUM_BANKS-1:0] cbr, bank_proto, rd_vld;
  logic [WORD_W-1:0]    rd_data [NUM_BANKS];
  bank_state_e          bank_st [NUM_BANKS];

  logic                 proto_err_q, proto_err_d;
  logic [15:0]          ref_count_q, ref_count_d;
  logic [16:0]          ref_sum;
  logic                 xd_oe_q, xd_oe_d;
  logic [WORD_W-1:0]    xd_out_q, xd_out_d;
  logic                 unused_ma;

  // Address bits above the configured row/column widths alias silently.
  assign unused_ma = ^xma;

  always_ff @(posedge xvclk) begin
    if (xreset) begin
      ras_q <= '1;
      cas_q <= '1;
    end else begin
      ras_q <= xrasl;
      cas_q <= xcasl;
    end
  end

  assign ras_fall = ras_q & ~xrasl;
  assign ras_rise = ~ras_q & xrasl;
  assign cas_fall = cas_q & ~xcasl;
  assign cas_rise = ~cas_q & xcasl;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    jag_dram_bank #(
      .ROW_BITS(ROW_BITS),
      .COL_BITS(COL_BITS),
      .CAS_LAT (CAS_LAT)
    ) u_bank (
      .clk_i     (xvclk),
      .rst_i     (xreset),
      .ras_fall_i(ras_fall[b]),
      .ras_rise_i(ras_rise[b]),
      .cas_fall_i(cas_fall[b]),
      .cas_rise_i(cas_rise[b]),
      .cas_low_i (~xcasl[b]),
      .oe_n_i    (xoel_0),
      .row_i     (xma[ROW_BITS-1:0]),
      .col_i     (xma[COL_BITS-1:0]),
      .we_n_i    (xwel),
      .wdata_i   (xd_in),
      .state_o   (bank_st[b]),
      .cbr_o     (cbr[b]),
      .proto_o   (bank_proto[b]),
      .rd_vld_o  (rd_vld[b]),
      .rd_data_o (rd_data[b])
    );
  end

  assign ref_sum     = {1'b0, ref_count_q} + 17'(cbr[0]) + 17'(cbr[1]);
  assign ref_count_d = ref_sum[16] ? 16'hFFFF : ref_sum[15:0];
  assign proto_err_d = proto_err_q || (|bank_proto) ||
                       ((bank_st[0] == CAS_ACT) && (bank_st[1] == CAS_ACT));

  // Bank 0 wins the data bus when both banks present read data.
  always_comb begin
    xd_oe_d  = |rd_vld;
    xd_out_d = xd_out_q;
    if (rd_vld[0])      xd_out_d = rd_data[0];
    else if (rd_vld[1]) xd_out_d = rd_data[1];
  end

  always_ff @(posedge xvclk) begin
    if (xreset) begin
      proto_err_q <= 1'b0;
      ref_count_q <= '0;
      xd_oe_q     <= 1'b0;
      xd_out_q    <= '0;
    end else begin
      proto_err_q <= proto_err_d;
      ref_count_q <= ref_count_d;
      xd_oe_q     <= xd_oe_d;
      xd_out_q    <= xd_out_d;
    end
  end

  assign xd_out    = xd_out_q;
  assign xd_oe     = xd_oe_q;
  assign proto_err = proto_err_q;
  assign ref_count = ref_count_q;

`ifdef JAG_DRAM_REFRESH_CHECK_EN
  localparam logic [15:0] REF_LIMIT = 16'(REF_MAX);

  logic [15:0] ref_tmr_q;
  logic        ref_err_q;

  always_ff @(posedge xvclk) begin
    if (xreset) begin
      ref_tmr_q <= '0;
      ref_err_q <= 1'b0;
    end else begin
      if (|cbr)                        ref_tmr_q <= '0;
      else if (ref_tmr_q != REF_LIMIT) ref_tmr_q <= ref_tmr_q + 16'd1;
      if (ref_tmr_q == REF_LIMIT)      ref_err_q <= 1'b1;
    end
  end

  assign ref_err = ref_err_q;
`else
  assign ref_err = 1'b0;
`endif

endmodule

// File: tb/tb_jag_dram_responder.sv
// Randomised scoreboard bench for jag_dram_responder against an address-map model.
module tb_jag_dram_responder;

  localparam int ROW_BITS = 6;
  localparam int COL_BITS = 6;
  localparam int CAS_LAT  = 2;
  localparam int REF_MAX  = 100;

  logic        clk = 1'b0;
  logic        xreset;
  logic [10:0] xma;
  logic [1:0]  xrasl, xcasl;
  logic        xoel_0;
  logic [7:0]  xwel;
  logic [63:0] xd_in, xd_out;
  logic        xd_oe, proto_err, ref_err;
  logic [15:0] ref_count;

  jag_dram_responder #(
    .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .CAS_LAT(CAS_LAT), .REF_MAX(REF_MAX)
  ) dut (
    .xvclk(clk), .xreset(xreset), .xma(xma), .xrasl(xrasl), .xcasl(xcasl),
    .xoel_0(xoel_0), .xwel(xwel), .xd_in(xd_in), .xd_out(xd_out), .xd_oe(xd_oe),
    .proto_err(proto_err), .ref_count(ref_count), .ref_err(ref_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  typedef struct { logic [63:0] data; int cyc; } exp_t;
  exp_t expq[$];

  // Reference model: one word per {bank,row,col} after truncation, with known-byte tracking.
  logic [63:0] mem_m   [int];
  logic [7:0]  known_m [int];
  int          cur_row [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int maddr(input int b, input int row, input int col);
    return (b << (ROW_BITS + COL_BITS)) + ((row % (1 << ROW_BITS)) << COL_BITS) + (col % (1 << COL_BITS));
  endfunction

  function automatic bit fully_known(input int a);
    return known_m.exists(a) && known_m[a] == 8'hFF;
  endfunction

  task automatic mwrite(input int a, input logic [7:0] mask, input logic [63:0] d);
    if (!known_m.exists(a)) begin
      known_m[a] = 8'h00;
      mem_m[a]   = '0;
    end
    for (int j = 0; j < 8; j++) begin
      if (!mask[j]) begin
        mem_m[a][j*8 +: 8] = d[j*8 +: 8];
        known_m[a][j]      = 1'b1;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ras_open(input int b, input int row);
    xma = 11'(row);
    xrasl[b] = 1'b0;
    cur_row[b] = row;
    tick(1);
  endtask

  task automatic ras_close(input int b);
    xrasl[b] = 1'b1;
    tick(1);
  endtask

  task automatic do_write(input int b, input int col, input logic [7:0] mask,
                          input logic [63:0] data, input bit oe_low);
    xma = 11'(col); xwel = mask; xd_in = data; xoel_0 = ~oe_low;
    xcasl[b] = 1'b0;
    tick(1);
    xcasl[b] = 1'b1; xwel = 8'hFF; xoel_0 = 1'b1;
    tick(1);
    mwrite(maddr(b, cur_row[b], col), mask, data);
  endtask

  task automatic do_read(input int b, input int col, input int hold, input bit end_by_oe);
    exp_t e;
    e.data = mem_m[maddr(b, cur_row[b], col)];
    e.cyc  = cyc + 1 + CAS_LAT;
    expq.push_back(e);
    xma = 11'(col); xwel = 8'hFF; xoel_0 = 1'b0;
    xcasl[b] = 1'b0;
    tick(CAS_LAT + 1 + hold);
    if (end_by_oe) begin
      xoel_0 = 1'b1;
      tick(2);
      chk("oe_drop_on_oe_rise", 64'(xd_oe), 64'd0);
      xcasl[b] = 1'b1;
      tick(1);
    end else begin
      xcasl[b] = 1'b1; xoel_0 = 1'b1;
      tick(2);
      chk("oe_drop_on_cas_rise", 64'(xd_oe), 64'd0);
    end
  endtask

  task automatic do_reset();
    xreset = 1'b1;
    tick(3);
    xreset = 1'b0;
    tick(1);
  endtask

  // Monitor: every rising xd_oe consumes one expected read; data must hold while enabled.
  logic        oe_prev = 1'b0;
  logic [63:0] held;
  always @(negedge clk) begin
    if (xd_oe === 1'b1 && oe_prev !== 1'b1) begin
      if (expq.size() == 0) begin
        tests++; fails++;
        $display("FAIL rd_unexpected: xd_oe rose with data %h, expected no read", xd_out);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("rd_data", xd_out, e.data);
        chk("rd_latency_cycle", 64'(cyc), 64'(e.cyc));
      end
      held = xd_out;
    end else if (xd_oe === 1'b1) begin
      chk("rd_hold", xd_out, held);
    end
    oe_prev = xd_oe;
  end

  int ref_exp;

  initial begin
    int b, row, col, a, nops;
    logic [7:0] m;
    xma = '0; xrasl = 2'b11; xcasl = 2'b11; xoel_0 = 1'b1; xwel = 8'hFF; xd_in = '0;
    cur_row[0] = 0; cur_row[1] = 0;
    ref_exp = 0;

    do_reset();
    chk("rst_xd_oe", 64'(xd_oe), 64'd0);
    chk("rst_xd_out", xd_out, 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    chk("rst_ref_count", 64'(ref_count), 64'd0);
    chk("rst_ref_err", 64'(ref_err), 64'd0);

    // Refresh: bank1 holds data across three CBR cycles.
    ras_open(1, 7);
    do_write(1, 9, 8'h00, 64'hA5A5_1234_5678_5A5A, 1'b0);
    ras_close(1);
    for (int i = 0; i < 3; i++) begin
      xcasl[1] = 1'b0; tick(1);
      xrasl[1] = 1'b0; tick(1);
      xrasl[1] = 1'b1; tick(1);
      xcasl[1] = 1'b1; tick(1);
      ref_exp++;
    end
    tick(2);
    chk("ref_count_cbr", 64'(ref_count), 64'(ref_exp));
    chk("ref_err_after_cbr", 64'(ref_err), 64'd0);
    ras_open(1, 7);
    do_read(1, 9, 0, 1'b0);
    ras_close(1);
    tick(REF_MAX + 10);
`ifdef JAG_DRAM_REFRESH_CHECK_EN
    chk("ref_err_timeout", 64'(ref_err), 64'd1);
`else
    chk("ref_err_tied", 64'(ref_err), 64'd0);
`endif

    // Full write then read at bank0 row 5 col 3, then a single-lane overwrite.
    ras_open(0, 5);
    do_write(0, 3, 8'h00, 64'h0123_4567_89AB_CDEF, 1'b0);
    do_read(0, 3, 1, 1'b0);
    do_write(0, 3, 8'hFE, 64'hDEAD_BEEF_0BAD_F055, 1'b0);
    do_read(0, 3, 0, 1'b1);
    ras_close(0);

    // Page mode: preload cols 0..3, then one RAS with four CAS reads.
    ras_open(0, 9);
    for (int i = 0; i < 4; i++) do_write(0, i, 8'h00, 64'(i + 1), 1'b0);
    ras_close(0);
    ras_open(0, 9);
    for (int i = 0; i < 4; i++) do_read(0, i, 0, 1'b0);
    ras_close(0);
    chk("page_proto_clean", 64'(proto_err), 64'd0);

    // Random traffic; high address bits exercise wrap-around aliasing.
    for (int t = 0; t < 40; t++) begin
      b    = int'($urandom_range(0, 1));
      row  = int'($urandom_range(0, 3)) + 64 * int'($urandom_range(0, 31));
      nops = int'($urandom_range(1, 4));
      ras_open(b, row);
      for (int k = 0; k < nops; k++) begin
        col = int'($urandom_range(0, 3)) + 64 * int'($urandom_range(0, 31));
        a   = maddr(b, row, col);
        if ($urandom_range(0, 1) == 1 && fully_known(a)) begin
          do_read(b, col, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end else begin
          m = fully_known(a) ? 8'($urandom_range(0, 254)) : 8'h00;
          do_write(b, col, m, {$urandom, $urandom}, 1'b0);
        end
      end
      ras_close(b);
    end
    chk("random_proto_clean", 64'(proto_err), 64'd0);

    // RAS rise while CAS still low.
    ras_open(0, 1);
    xma = 11'd2; xcasl[0] = 1'b0;
    tick(2);
    xrasl[0] = 1'b1;
    tick(2);
    chk("proto_ras_rise_in_cas", 64'(proto_err), 64'd1);
    xcasl[0] = 1'b1;
    tick(4);
    chk("proto_sticky", 64'(proto_err), 64'd1);
    do_reset();
    chk("proto_cleared_by_reset", 64'(proto_err), 64'd0);

    // Write with output enable asserted: write lands, no read, error flagged.
    ras_open(0, 5);
    do_write(0, 3, 8'h7F, 64'hC3C3_C3C3_C3C3_C3C3, 1'b1);
    tick(2);
    chk("proto_write_with_oe", 64'(proto_err), 64'd1);
    do_read(0, 3, 0, 1'b0);
    ras_close(0);
    do_reset();

    // Both banks in CAS_ACT together.
    ras_open(0, 1);
    ras_open(1, 2);
    xcasl = 2'b00;
    tick(3);
    chk("proto_dual_cas_act", 64'(proto_err), 64'd1);
    xcasl = 2'b11; tick(1);
    xrasl = 2'b11; tick(3);

    chk("scoreboard_drained", 64'(expq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
